// File: rtl/mac_div_if.sv
// Handshake and data bundle between a division requester and the mac_div engine.
// The master issues start with operands; the slave returns busy/done and results.
interface mac_div_if #(
  parameter int N = 16
);
  logic             start;
  logic [2*N-1:0]   R;
  logic [N-1:0]     B;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   Q;
  logic [N-1:0]     Rm;
  logic             dz;

  modport master (
    output start, R, B,
    input  busy, done, Q, Rm, dz
  );

  modport slave (
    input  start, R, B,
    output busy, done, Q, Rm, dz
  );
endinterface

// File: rtl/mac_div.sv
// Sequential restoring divider recovering Q = R / B and Rm = R mod B from a MAC result.
// One quotient bit per clock; start/busy/done handshake, all outputs registered.
module mac_div #(
  parameter int N = 16
) (
  input  logic      clk,
  input  logic      rst,
  mac_div_if.slave  bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    dvd;
  logic [W-1:0]    quo;
  logic [N-1:0]    dvs;
  logic [N:0]      part;
  logic [CW-1:0]   cnt;

  logic [N:0]      shifted;
  logic [N:0]      trial;
  logic            take;
  logic [N:0]      part_nxt;
  logic [W-1:0]    quo_nxt;
  logic            last;

  // One restoring step: the partial is always < divisor before the shift, so
  // N+1 bits hold the shifted value and the subtraction never underflows when taken.
  // NOTE: every combinational output is assigned unconditionally here, so no latch can be inferred.
  always_comb begin
    shifted  = {part[N-1:0], dvd[W-1]};
    trial    = shifted - {1'b0, dvs};
    take     = (shifted >= {1'b0, dvs});
    part_nxt = take ? trial : shifted;
    quo_nxt  = {quo[W-2:0], take};
    last     = (cnt == CW'(W - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dvd      <= '0;
      quo      <= '0;
      dvs      <= '0;
      part     <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Q    <= '0;
      bus.Rm   <= '0;
      bus.dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            if (bus.B != '0) begin
              dvd      <= bus.R;
              dvs      <= bus.B;
              part     <= '0;
              quo      <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= RUN;
            end else begin
              // Divide by zero resolves in one cycle without touching the datapath.
              bus.Q    <= '1;
              bus.Rm   <= '0;
              bus.dz   <= 1'b1;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end

        RUN: begin
          part <= part_nxt;
          dvd  <= {dvd[W-2:0], 1'b0};
          quo  <= quo_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            bus.Q    <= quo_nxt;
            bus.Rm   <= part_nxt[N-1:0];
            bus.dz   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_div.sv
// Self-checking bench for mac_div: directed vector table, multi-cycle corner
// sequences, and randomized back-to-back divisions against an arithmetic model.
module tb_mac_div;
  localparam int N = 16;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  mac_div_if #(.N(N)) bus ();

  mac_div #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] rm;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that brings it back to IDLE.
  task automatic run_op(input logic [31:0] r, input logic [15:0] b,
                        output logic [31:0] q, output logic [15:0] rm, output logic d,
                        output int lat, output int busy_cnt, output int overlap,
                        output int got_done);
    bus.start = 1'b1;
    bus.R     = r;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    got_done = int'(bus.done);
    overlap  = int'(bus.busy && bus.done);
    q  = bus.Q;
    rm = bus.Rm;
    d  = bus.dz;
    @(posedge clk); #1;
  endtask

  vec_t        vecs[6];
  logic [31:0] q, r;
  logic [15:0] rm, b;
  logic        d;
  int          lat, busy_cnt, overlap, got_done, dones, done_lat, prev, wait_cnt;
  logic [63:0] ident;

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{r: 32'd699767,   b: 16'd567,    q: 32'd1234,       rm: 16'd89, dz: 1'b0};
    vecs[1] = '{r: 32'hFFFFFFFF, b: 16'd1,      q: 32'hFFFFFFFF,   rm: 16'd0,  dz: 1'b0};
    vecs[2] = '{r: 32'hFFFFFFFF, b: 16'hFFFF,   q: 32'h00010001,   rm: 16'd0,  dz: 1'b0};
    vecs[3] = '{r: 32'd5,        b: 16'd7,      q: 32'd0,          rm: 16'd5,  dz: 1'b0};
    vecs[4] = '{r: 32'd1000,     b: 16'd0,      q: 32'hFFFFFFFF,   rm: 16'd0,  dz: 1'b1};
    vecs[5] = '{r: 32'd10,       b: 16'd3,      q: 32'd3,          rm: 16'd1,  dz: 1'b0};

    bus.start = 1'b0;
    bus.R     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    #12;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_q",    bus.Q,    0);
    check("reset_rm",   bus.Rm,   0);
    check("reset_dz",   bus.dz,   0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].r, vecs[i].b, q, rm, d, lat, busy_cnt, overlap, got_done);
      check($sformatf("vec%0d_done", i), got_done, 1);
      check($sformatf("vec%0d_q", i),    q,  vecs[i].q);
      check($sformatf("vec%0d_rm", i),   rm, vecs[i].rm);
      check($sformatf("vec%0d_dz", i),   d,  vecs[i].dz);
      check($sformatf("vec%0d_lat", i),  lat, (vecs[i].b != 0) ? 32 : 0);
      check($sformatf("vec%0d_busy_cycles", i), busy_cnt, (vecs[i].b != 0) ? 32 : 0);
      check($sformatf("vec%0d_busy_done_overlap", i), overlap, 0);
    end

    // Ignored start: re-pulses during RUN (cycle 5) and DONE (cycle 32).
    bus.start = 1'b1;
    bus.R     = 32'd699767;
    bus.B     = 16'd567;
    @(posedge clk); #1;
    dones = 0; done_lat = -1; q = '0; rm = '0;
    for (int k = 0; k < 45; k++) begin
      if (k == 5 || k == 32) begin
        bus.start = 1'b1;
        bus.R     = 32'h12345678;
        bus.B     = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        done_lat = k + 1;
        q  = bus.Q;
        rm = bus.Rm;
      end
    end
    bus.start = 1'b0;
    check("ignored_start_done_count", dones, 1);
    check("ignored_start_lat", done_lat, 32);
    check("ignored_start_q",  q,  32'd1234);
    check("ignored_start_rm", rm, 16'd89);

    // Reset mid-run: outputs clear asynchronously, and no done follows.
    bus.start = 1'b1;
    bus.R     = 32'hFFFFFFFF;
    bus.B     = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("midrun_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", bus.busy, 0);
    check("midrun_rst_done", bus.done, 0);
    check("midrun_rst_q",    bus.Q,    0);
    check("midrun_rst_rm",   bus.Rm,   0);
    check("midrun_rst_dz",   bus.dz,   0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    check("midrun_no_activity_after_rst", dones, 0);
    run_op(32'd100, 16'd9, q, rm, d, lat, busy_cnt, overlap, got_done);
    check("post_rst_q",   q,   32'd11);
    check("post_rst_rm",  rm,  16'd1);
    check("post_rst_dz",  d,   0);
    check("post_rst_lat", lat, 32);

    // Randomized back-to-back with start held high; new operands are presented
    // on each done, ahead of the next accept edge.
    r = $urandom;
    b = 16'($urandom_range(1, 65535));
    bus.R     = r;
    bus.B     = b;
    bus.start = 1'b1;
    prev = -1;
    for (int i = 0; i < 1000; i++) begin
      wait_cnt = 0;
      while (!bus.done && wait_cnt < 100) begin
        @(posedge clk); #1;
        wait_cnt++;
      end
      if (!bus.done) begin
        check("rand_timeout", bus.done, 1);
        break;
      end
      ident = 64'(bus.Q) * 64'(b) + 64'(bus.Rm);
      check("rand_q",        bus.Q,  r / 32'(b));
      check("rand_rm",       bus.Rm, 16'(r % 32'(b)));
      check("rand_identity", ident,  64'(r));
      check("rand_rm_lt_b",  64'(bus.Rm < b), 1);
      check("rand_dz",       bus.dz, 0);
      if (prev >= 0) check("rand_spacing", cyc - prev, 34);
      prev = cyc;
      r = $urandom;
      if (i % 8 == 0) b = 16'($urandom_range(1, 15));
      else            b = 16'($urandom_range(1, 65535));
      bus.R = r;
      bus.B = b;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (40) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
